// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// id_stage : IF/ID register, 32x32 register file with write-first bypass,
//            RV32I immediate generation and main control decode.
// Revision : 1.0
// ============================================================================
module id_stage #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_present,
  input  logic [31:0]     inst,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            alu_src,
  output logic            illegal
);

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;

  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_inst_q, id_inst_d;
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  // IF/ID register: flush beats stall, stall beats load
  always_comb begin
    id_valid_d = 1'b1;
    id_pc_d    = pc_present;
    id_inst_d  = inst;
    if (flush) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (stall) begin
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_rd != 5'd0)) begin
      regs_d[wb_rd] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      regs_q     <= regs_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign rs1      = id_inst_q[19:15];
  assign rs2      = id_inst_q[24:20];
  assign rd       = id_inst_q[11:7];
  assign opcode   = id_inst_q[6:0];
  assign funct3   = id_inst_q[14:12];
  assign funct7b5 = id_inst_q[30];

  // Write-first: a same-cycle write-back to the read register is forwarded
  always_comb begin
    rs1_data = regs_q[rs1];
    rs2_data = regs_q[rs2];
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1)) rs1_data = wb_data;
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2)) rs2_data = wb_data;
    if (rs1 == 5'd0) rs1_data = '0;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  logic [5:0]  ctrl_raw;
  logic        known_op;
  logic [31:0] imm32;
  logic        sgn;

  assign sgn = id_inst_q[31];

  // ctrl_raw order: reg_write, mem_read, mem_write, branch, jump, alu_src
  always_comb begin
    ctrl_raw = 6'b000000;
    known_op = 1'b1;
    imm32    = 32'd0;
    case (opcode)
      C_OP_R: ctrl_raw = 6'b100000;
      C_OP_IMM: begin
        ctrl_raw = 6'b100001;
        imm32    = {{20{sgn}}, id_inst_q[31:20]};
      end
      C_OP_LOAD: begin
        ctrl_raw = 6'b110001;
        imm32    = {{20{sgn}}, id_inst_q[31:20]};
      end
      C_OP_STORE: begin
        ctrl_raw = 6'b001001;
        imm32    = {{20{sgn}}, id_inst_q[31:25], id_inst_q[11:7]};
      end
      C_OP_BRANCH: begin
        ctrl_raw = 6'b000100;
        imm32    = {{19{sgn}}, sgn, id_inst_q[7], id_inst_q[30:25], id_inst_q[11:8], 1'b0};
      end
      C_OP_JAL: begin
        ctrl_raw = 6'b100010;
        imm32    = {{11{sgn}}, sgn, id_inst_q[19:12], id_inst_q[20], id_inst_q[30:21], 1'b0};
      end
      C_OP_JALR: begin
        ctrl_raw = 6'b100011;
        imm32    = {{20{sgn}}, id_inst_q[31:20]};
      end
      C_OP_LUI, C_OP_AUIPC: begin
        ctrl_raw = 6'b100001;
        imm32    = {id_inst_q[31:12], 12'd0};
      end
      default: known_op = 1'b0;
    endcase
  end

  assign imm     = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  assign illegal = id_valid_q && !known_op;

  // Bubbles and illegal instructions must not produce side effects downstream
  assign {reg_write, mem_read, mem_write, branch, jump, alu_src} =
      (id_valid_q && known_op) ? ctrl_raw : 6'b000000;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// tb_id_stage : self-checking bench for id_stage (vector table + sequences).
// Revision    : 1.0
// ============================================================================
module tb_id_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc_present;
  logic [31:0] inst;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        reg_write, mem_read, mem_write, branch, jump, alu_src, illegal;
  logic [5:0]  ctrl;

  assign ctrl = {reg_write, mem_read, mem_write, branch, jump, alu_src};

  id_stage #(.XLEN(32), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .pc_present(pc_present), .inst(inst),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .alu_src(alu_src), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  ctrl;
    logic        illegal;
  } vec_t;

  vec_t vecs [12];
  vec_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ctrl order: reg_write, mem_read, mem_write, branch, jump, alu_src
    vecs[0]  = '{32'h00A0_0093, 32'h0000_0004, 32'h0000_000A, 6'b100001, 1'b0}; // addi x1,x0,10
    vecs[1]  = '{32'h0052_8333, 32'h0000_0008, 32'h0000_0000, 6'b100000, 1'b0}; // add
    vecs[2]  = '{32'h1234_50B7, 32'h0000_000C, 32'h1234_5000, 6'b100001, 1'b0}; // lui
    vecs[3]  = '{32'hFE00_0EE3, 32'h0000_0010, 32'hFFFF_FFFC, 6'b000100, 1'b0}; // beq -4
    vecs[4]  = '{32'h0000_006F, 32'h0000_0014, 32'h0000_0000, 6'b100010, 1'b0}; // jal x0,0
    vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0018, 32'h0000_0000, 6'b000000, 1'b1}; // illegal
    vecs[6]  = '{32'hFF81_2283, 32'h0000_001C, 32'hFFFF_FFF8, 6'b110001, 1'b0}; // lw x5,-8(x2)
    vecs[7]  = '{32'h0051_2623, 32'h0000_0020, 32'h0000_000C, 6'b001001, 1'b0}; // sw x5,12(x2)
    vecs[8]  = '{32'h0041_00E7, 32'h0000_0024, 32'h0000_0004, 6'b100011, 1'b0}; // jalr x1,4(x2)
    vecs[9]  = '{32'h8000_0197, 32'h0000_0028, 32'h8000_0000, 6'b100001, 1'b0}; // auipc
    vecs[10] = '{32'h0000_0010, 32'h0000_002C, 32'h0000_0000, 6'b000000, 1'b1}; // inst[1:0]!=11
    vecs[11] = '{32'h8000_006F, 32'h0000_0030, 32'hFFF0_0000, 6'b100010, 1'b0}; // jal, min offset

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = '0;
    pc_present = '0; inst = 32'h0000_0013;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'h0000_0013);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_ctrl", {26'd0, ctrl}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_rs1_data", rs1_data, 32'd0);
    chk("rst_rs2_data", rs2_data, 32'd0);

    for (int i = 0; i < 12; i++) begin
      inst       = vecs[i].inst;
      pc_present = vecs[i].pc;
      sb.push_back(vecs[i]);
      step();
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk($sformatf("v%0d_valid", i), {31'd0, id_valid}, 32'd1);
        chk($sformatf("v%0d_pc", i), id_pc, e.pc);
        chk($sformatf("v%0d_inst", i), id_inst, e.inst);
        chk($sformatf("v%0d_imm", i), imm, e.imm);
        chk($sformatf("v%0d_ctrl", i), {26'd0, ctrl}, {26'd0, e.ctrl});
        chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, e.illegal});
        chk($sformatf("v%0d_opcode", i), {25'd0, opcode}, {25'd0, e.inst[6:0]});
        chk($sformatf("v%0d_rd", i), {27'd0, rd}, {27'd0, e.inst[11:7]});
        chk($sformatf("v%0d_rs1", i), {27'd0, rs1}, {27'd0, e.inst[19:15]});
        chk($sformatf("v%0d_rs2", i), {27'd0, rs2}, {27'd0, e.inst[24:20]});
        chk($sformatf("v%0d_f3", i), {29'd0, funct3}, {29'd0, e.inst[14:12]});
        chk($sformatf("v%0d_f7b5", i), {31'd0, funct7b5}, {31'd0, e.inst[30]});
      end
    end

    // same-cycle bypass, then the written value from the array
    inst = 32'h0052_8333; pc_present = 32'h100;
    step();
    stall = 1'b1; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
    chk("byp_rs1", rs1_data, 32'hDEAD_BEEF);
    chk("byp_rs2", rs2_data, 32'hDEAD_BEEF);
    step();
    wb_en = 1'b0;
    #1;
    chk("wr_rs1", rs1_data, 32'hDEAD_BEEF);
    chk("wr_rs2", rs2_data, 32'hDEAD_BEEF);

    // writes to x0 are neither bypassed nor stored
    stall = 1'b0; inst = 32'h00A0_0093; pc_present = 32'h104;
    step();
    stall = 1'b1; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    #1;
    chk("x0_byp", rs1_data, 32'd0);
    step();
    wb_en = 1'b0;
    #1;
    chk("x0_after", rs1_data, 32'd0);

    // stall holds for 3 cycles while IF keeps changing
    stall = 1'b0; inst = 32'h1234_50B7; pc_present = 32'h200;
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inst = $urandom; pc_present = $urandom;
      step();
      chk($sformatf("stall%0d_inst", k), id_inst, 32'h1234_50B7);
      chk($sformatf("stall%0d_imm", k), imm, 32'h1234_5000);
      chk($sformatf("stall%0d_pc", k), id_pc, 32'h200);
    end
    flush = 1'b1; pc_present = 32'h300;
    step();
    flush = 1'b0; stall = 1'b0;
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_inst", id_inst, 32'h0000_0013);
    chk("flush_pc", id_pc, 32'h300);
    chk("flush_rw", {31'd0, reg_write}, 32'd0);

    // reset during a write-back clears the target register
    inst = 32'h0001_8213; pc_present = 32'h400;   // addi x4,x3,0
    step();
    stall = 1'b1; wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h77;
    step();
    wb_en = 1'b0;
    #1;
    chk("x3_written", rs1_data, 32'h77);
    stall = 1'b0; reset = 1'b1; wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    step();
    reset = 1'b0; wb_en = 1'b0;
    #1;
    chk("rstwr_valid", {31'd0, id_valid}, 32'd0);
    chk("rstwr_inst", id_inst, 32'h0000_0013);
    inst = 32'h0001_8213; pc_present = 32'h404;
    step();
    chk("rstwr_x3", rs1_data, 32'd0);
    chk("rstwr_valid2", {31'd0, id_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction Decode stage, directly downstream of the IF block. It contains:
- the IF/ID pipeline register, with stall and flush;
- the 32x32 integer register file, with a write-back port and write-first bypass;
- RV32I immediate generation;
- main control decode.

All decoded outputs are driven combinationally from the latched IF/ID contents. They feed the ID/EX boundary.

Parameters:
XLEN, 32, datapath and register width
NOP_INST, 32'h00000013, instruction loaded on reset or flush (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pc_present  in  XLEN  PC of the instruction fetched by IF
inst  in  32  instruction word from IF
stall  in  1  hold the IF/ID register
flush  in  1  replace the IF/ID contents with a bubble
wb_en  in  1  register-file write enable
wb_rd  in  5  write-back destination register
wb_data  in  XLEN  write-back data
id_valid  out  1  the latched instruction is real, not a bubble
id_pc  out  XLEN  latched PC
id_inst  out  32  latched instruction
rs1, rs2, rd  out  5 each  register fields, id_inst[19:15], [24:20], [11:7]
opcode  out  7  id_inst[6:0]
funct3  out  3  id_inst[14:12]
funct7b5  out  1  id_inst[30]
rs1_data, rs2_data  out  XLEN  register-file read data, after bypass
imm  out  XLEN  sign-extended immediate
reg_write, mem_read, mem_write, branch, jump, alu_src  out  1 each  control signals
illegal  out  1  id_valid is high and the opcode is unsupported

Behaviour:
IF/ID register (posedge clk), priority reset > flush > stall > load:
- reset: id_valid=0, id_pc=0, id_inst=NOP_INST; all 32 registers cleared to 0.
- flush: id_valid=0, id_inst=NOP_INST, id_pc=pc_present. Flush wins over a simultaneous stall.
- stall, with no flush: all IF/ID fields hold.
- otherwise: id_pc<=pc_present, id_inst<=inst, id_valid<=1.
- Latency: an instruction presented at edge N appears on the decode outputs after edge N.

Register file:
- Write at posedge when wb_en=1 and wb_rd!=0. Writes to x0 are discarded; x0 always reads 0.
- Reads are combinational.
- Write-first bypass: if wb_en=1, wb_rd!=0 and wb_rd==rs1, then rs1_data=wb_data in the same cycle. rs2 behaves identically.
- A reset asserted mid-write wins; the register is cleared, not written.

Immediates (sign bit always inst[31]):
- I-type: load, OP-IMM, JALR.
- S-type: store.
- B-type: branch, bit0=0.
- U-type: LUI, AUIPC, low 12 bits zero.
- J-type: JAL, bit0=0.
- R-type and illegal: imm=0.

Control table (any unlisted signal is 0):
- R-type 0110011: reg_write.
- OP-IMM 0010011: reg_write, alu_src.
- LOAD 0000011: reg_write, alu_src, mem_read.
- STORE 0100011: alu_src, mem_write.
- BRANCH 1100011: branch.
- JAL 1101111: reg_write, jump.
- JALR 1100111: reg_write, jump, alu_src.
- LUI 0110111 and AUIPC 0010111: reg_write, alu_src.

Illegal and bubble handling:
- illegal=1 when id_valid=1 and opcode is not in the table; this includes inst[1:0]!=2'b11.
- When id_valid=0 or illegal=1, all six control signals are forced to 0.
- Field outputs (rs1, rd, imm, ...) still reflect id_inst.

Test Plan:
1. Hold reset high 2 cycles, then observe before any load -> id_valid=0, id_inst=0x00000013, id_pc=0, all controls 0, rs1_data=rs2_data=0.
2. pc_present=0x4, inst=0x00A00093 (addi x1,x0,10), one edge -> id_valid=1, id_pc=0x4, rd=1, rs1=0, imm=0x0000000A, reg_write=1, alu_src=1, mem_*=0, illegal=0.
3. Latch 0x00528333 (add x6,x5,x5) while wb_en=1, wb_rd=5, wb_data=0xDEADBEEF -> same cycle rs1_data=rs2_data=0xDEADBEEF. After the edge with wb_en=0, still 0xDEADBEEF.
   Then wb_rd=0, wb_data=0x1234 with rs1=0 -> rs1_data=0 before and after the edge.
4. Latch 0x123450B7 (lui x1,0x12345), then stall=1 for 3 cycles while inst changes each cycle -> id_inst stays 0x123450B7 and imm=0x12345000.
   Then stall=1 and flush=1 together -> id_valid=0, id_inst=0x00000013, reg_write=0.
5. Latch 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch=1, reg_write=0.
   Then 0x0000006F (jal x0,0) -> jump=1, imm=0.
6. Latch 0xFFFFFFFF -> illegal=1, all controls 0.
   Then reset asserted mid-stream with wb_en=1, wb_rd=3, wb_data=0x55 -> after the edge x3 reads 0 and id_valid=0.
